// File: rtl/bip_debug_tx_pkg.sv
// Shared definitions for the BIP debug transmitter: frame header, FSM encodings
// and the baud divider helper.
package bip_debug_tx_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LOAD,
        F_SEND,
        F_DONE
    } frame_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/bip_uart_tx.sv
// Single-byte 8N1 serializer, LSB first.
//  state   | meaning
//  U_IDLE  | line high, waiting for i_start
//  U_START | driving start bit (0)
//  U_DATA  | driving d0..d7
//  U_STOP  | driving stop bit (1); o_byte_done on its final cycle
// A start presented on the final stop-bit cycle chains the next byte directly,
// so consecutive bytes leave no idle gap on the line.
module bip_uart_tx
    import bip_debug_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_byte_done,
    output logic       o_idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          baud_tc;

    assign baud_tc = (baud_q == '0);

    // Next-state, baud down-counter and serial bit selection
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        o_byte_done = 1'b0;
        case (state_q)
            U_IDLE: begin
                tx_d = 1'b1;
                if (i_start) begin
                    state_d = U_START;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_LOAD;
                    shreg_d = i_data;
                end
            end
            U_START: begin
                if (baud_tc) begin
                    state_d   = U_DATA;
                    tx_d      = shreg_q[0];
                    baud_d    = BAUD_LOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            U_DATA: begin
                if (baud_tc) begin
                    baud_d = BAUD_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = U_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            U_STOP: begin
                if (baud_tc) begin
                    o_byte_done = 1'b1;
                    if (i_start) begin
                        state_d = U_START;
                        tx_d    = 1'b0;
                        baud_d  = BAUD_LOAD;
                        shreg_d = i_data;
                    end else begin
                        state_d = U_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = U_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serializer registers; line idles high
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= U_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_idle = (state_q == U_IDLE);

endmodule

// File: rtl/bip_debug_tx.sv
// Observes BIP halt/accumulator, counts cycles to halt and sends one result
// frame: A5, ACC bytes MSB-first, CNT bytes MSB-first.
// Optional: BIP_DEBUG_CHKSUM_EN appends an XOR checksum byte over all prior bytes.
//  state  | meaning
//  F_IDLE | waiting for halt rising edge
//  F_LOAD | capturing ACC and cycle count into frame registers
//  F_SEND | serializing frame bytes back-to-back
//  F_DONE | one-cycle o_done pulse, then back to idle
module bip_debug_tx
    import bip_debug_tx_pkg::*;
#(
    parameter int NBITS_D   = 16,
    parameter int NBITS_CNT = 16,
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_Halt,
    input  logic [NBITS_D-1:0] i_ACC,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int NBYTES_BASE  = 1 + NBITS_D / 8 + NBITS_CNT / 8;
`ifdef BIP_DEBUG_CHKSUM_EN
    localparam int NBYTES = NBYTES_BASE + 1;
`else
    localparam int NBYTES = NBYTES_BASE;
`endif
    localparam int IDXW = $clog2(NBYTES);

    frame_state_t         state_q, state_d;
    logic                 halt_q;
    logic                 halt_rise;
    logic [NBITS_CNT-1:0] cnt_q, cnt_d;
    logic [NBITS_D-1:0]   acc_q, acc_d;
    logic [NBITS_CNT-1:0] snap_q, snap_d;
    logic [IDXW-1:0]      byte_idx_q, byte_idx_d;
    logic [NBYTES*8-1:0]  frame_vec;
    logic [7:0]           byte_data;
    logic                 uart_start;
    logic                 uart_byte_done;
    logic                 uart_idle;

    assign halt_rise = i_Halt & ~halt_q;

    // Saturating cycle counter, frozen while halted
    always_comb begin
        cnt_d = cnt_q;
        if (!i_Halt && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

`ifdef BIP_DEBUG_CHKSUM_EN
    logic [7:0] chksum;

    // XOR of header and every captured byte
    always_comb begin
        chksum = FRAME_HEADER;
        for (int i = 0; i < NBITS_D / 8; i++) chksum = chksum ^ acc_q[i*8 +: 8];
        for (int i = 0; i < NBITS_CNT / 8; i++) chksum = chksum ^ snap_q[i*8 +: 8];
    end

    assign frame_vec = {FRAME_HEADER, acc_q, snap_q, chksum};
`else
    assign frame_vec = {FRAME_HEADER, acc_q, snap_q};
`endif

    // Byte 0 sits in the top byte of frame_vec
    assign byte_data = 8'(frame_vec >> ((NBYTES - 1 - int'(byte_idx_d)) * 8));

    // Frame FSM: trigger, capture, byte sequencing
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        snap_d     = snap_q;
        byte_idx_d = byte_idx_q;
        uart_start = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (halt_rise) state_d = F_LOAD;
            end
            F_LOAD: begin
                acc_d      = i_ACC;
                snap_d     = cnt_q;
                byte_idx_d = '0;
                state_d    = F_SEND;
            end
            F_SEND: begin
                if (uart_byte_done) begin
                    if (byte_idx_q == IDXW'(NBYTES - 1)) begin
                        state_d = F_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        uart_start = 1'b1;
                    end
                end else if (uart_idle) begin
                    uart_start = 1'b1;
                end
            end
            F_DONE: begin
                state_d = F_IDLE;
            end
            default: state_d = F_IDLE;
        endcase
    end

    // Control and frame registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= F_IDLE;
            halt_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            snap_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            halt_q     <= i_Halt;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            snap_q     <= snap_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    bip_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (uart_start),
        .i_data     (byte_data),
        .o_tx       (o_tx),
        .o_byte_done(uart_byte_done),
        .o_idle     (uart_idle)
    );

    assign o_busy = (state_q == F_SEND);
    assign o_done = (state_q == F_DONE);

endmodule

// File: tb/tb_bip_debug_tx.sv
// Self-checking bench for bip_debug_tx at 16 clocks per bit.
module tb_bip_debug_tx;

    localparam int CPB      = 16;
    localparam int BYTE_CYC = 10 * CPB;
`ifdef BIP_DEBUG_CHKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_Halt;
    logic [15:0] i_ACC;
    logic        o_tx, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    bip_debug_tx #(
        .NBITS_D  (16),
        .NBITS_CNT(16),
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .i_clk  (clk),
        .i_reset(i_reset),
        .i_Halt (i_Halt),
        .i_ACC  (i_ACC),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    typedef struct {
        int unsigned idle;
        logic [15:0] acc;
        logic [15:0] exp_cnt;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_frame(input logic [15:0] acc, input logic [15:0] cnt);
        logic [7:0] x;
        exp_q = {8'hA5, acc[15:8], acc[7:0], cnt[15:8], cnt[7:0]};
`ifdef BIP_DEBUG_CHKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`endif
    endfunction

    // Expected line level c cycles after the first start bit began
    function automatic logic line_at(input int c);
        int b;
        int pos;
        logic [7:0] byt;
        b   = c / BYTE_CYC;
        pos = (c % BYTE_CYC) / CPB;
        byt = exp_q[b];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos-1];
    endfunction

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        i_Halt  = 1'b0;
        repeat (n) begin
            tick();
            chk("rst_tx", o_tx, 1);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
        end
        i_reset = 1'b0;
    endtask

    task automatic idle(input int n);
        int bad = 0;
        i_Halt = 1'b0;
        repeat (n) begin
            tick();
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);
    endtask

    task automatic run_frame(input logic [15:0] acc, input logic [15:0] cnt,
                             input bit toggle, input string name);
        int bad_tx = 0;
        int bad_ctl = 0;
        build_frame(acc, cnt);
        i_ACC  = acc;
        i_Halt = 1'b1;
        tick();
        chk({name, "_k_busy"}, o_busy, 0);
        chk({name, "_k_tx"}, o_tx, 1);
        tick();
        chk({name, "_k1_busy"}, o_busy, 1);
        chk({name, "_k1_tx"}, o_tx, 1);
        for (int c = 0; c < NB * BYTE_CYC; c++) begin
            tick();
            if (o_tx !== line_at(c)) begin
                bad_tx++;
                if (bad_tx <= 3) $display("FAIL %s_bit cycle %0d got %b expected %b", name, c, o_tx, line_at(c));
            end
            if (o_busy !== 1'b1 || o_done !== 1'b0) bad_ctl++;
            if (toggle) i_Halt = 1'($urandom_range(0, 1));
        end
        chk({name, "_line_errs"}, bad_tx, 0);
        chk({name, "_busy_errs"}, bad_ctl, 0);
        i_Halt = 1'b1;
        tick();
        chk({name, "_done"}, o_done, 1);
        chk({name, "_done_busy"}, o_busy, 0);
        chk({name, "_done_tx"}, o_tx, 1);
        tick();
        chk({name, "_done_end"}, o_done, 0);
        chk({name, "_post_busy"}, o_busy, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int n;
        int bad;
        logic [15:0] acc;

        vecs[0] = '{100, 16'h1234, 16'h0064};
        vecs[1] = '{0,   16'h0000, 16'h0000};
        vecs[2] = '{1,   16'hFFFF, 16'h0001};
        vecs[3] = '{255, 16'h8001, 16'h00FF};
        vecs[4] = '{300, 16'h5A3C, 16'h012C};

        i_reset = 1'b1;
        i_Halt  = 1'b0;
        i_ACC   = 16'h0;

        for (int v = 0; v < 5; v++) begin
            do_reset(5);
            idle(int'(vecs[v].idle));
            run_frame(vecs[v].acc, vecs[v].exp_cnt, 1'b0, $sformatf("vec%0d", v));
        end

        // Counter survives a frame: 300 + 20 more non-halted cycles
        idle(20);
        run_frame(16'h0F0F, 16'd320, 1'b0, "noclear");

        // Reset and halt rise on the same edge: no frame
        i_reset = 1'b1;
        i_Halt  = 1'b1;
        repeat (3) begin
            tick();
            chk("simul_busy", o_busy, 0);
            chk("simul_tx", o_tx, 1);
        end
        i_Halt = 1'b0;
        tick();
        i_reset = 1'b0;
        idle(10);

        // Reset during bit 3 of byte 2, then a fresh frame with counter restarted
        do_reset(2);
        idle(100);
        build_frame(16'h1234, 16'h0064);
        i_ACC  = 16'h1234;
        i_Halt = 1'b1;
        tick();
        tick();
        bad = 0;
        for (int c = 0; c < 2 * BYTE_CYC + 4 * CPB + 5; c++) begin
            tick();
            if (o_tx !== line_at(c)) bad++;
        end
        chk("midrst_pre_line", bad, 0);
        chk("midrst_pre_busy", o_busy, 1);
        i_reset = 1'b1;
        i_Halt  = 1'b0;
        tick();
        chk("midrst_tx", o_tx, 1);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_done, 0);
        tick();
        chk("midrst_done2", o_done, 0);
        i_reset = 1'b0;
        idle(50);
        run_frame(16'hBEEF, 16'd50, 1'b0, "after_rst");

        // Halt toggled during busy, then held high: only one frame
        do_reset(2);
        idle(40);
        run_frame(16'hC3A1, 16'd40, 1'b1, "toggle");
        bad = 0;
        repeat (400) begin
            tick();
            if (o_busy !== 1'b0 || o_tx !== 1'b1 || o_done !== 1'b0) bad++;
        end
        chk("no_resend", bad, 0);

        // Randomized frames against counter/frame model
        for (int r = 0; r < 3; r++) begin
            do_reset(2);
            n   = int'($urandom_range(0, 400));
            acc = 16'($urandom);
            idle(n);
            run_frame(acc, 16'(n), 1'b0, $sformatf("rand%0d", r));
        end

        // Saturation: more non-halted cycles than the counter can hold
        do_reset(2);
        idle(70000);
        run_frame(16'hFFFF, 16'hFFFF, 1'b0, "sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
